// File: rtl/tick_period_meter.sv
// Frame-tick health monitor: synchronises an asynchronous slow tick, strobes
// each rising edge, measures edge-to-edge period in clk cycles, flags and
// counts out-of-range periods, and declares loss of tick on timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | disabled or unarmed; cnt held 0, first edge only arms
// ST_MEASURE | counting cycles since last edge; each edge yields a period
// ST_LOST  | no edge for TIMEOUT_CYCLES; lost high, next edge re-arms only
module tick_period_meter #(
  parameter int CNT_W          = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_PERIOD     = 1600000,
  parameter int MAX_PERIOD     = 1733334,
  parameter int TIMEOUT_CYCLES = 3333334,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             lost,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOST    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_SAT = {ERR_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_pulse_q, edge_pulse_d;
  logic                   rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   in_range_q, in_range_d;
  logic                   lost_q, lost_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic                   cnt_in_range;

  // Synchroniser shift, edge history and rising-edge detect.
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], tick_in};
    prev_d       = sync_q[SYNC_STAGES-1];
    rise         = sync_q[SYNC_STAGES-1] & ~prev_q;
    edge_pulse_d = rise;
  end

  // Synchroniser and edge registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      edge_pulse_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      edge_pulse_q <= edge_pulse_d;
    end
  end

  // Next-state, period counter and measurement outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    in_range_d     = in_range_q;
    lost_d         = lost_q;
    err_d          = err_q;
    cnt_in_range   = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);

    if (!enable) begin
      // Measurement results are kept; only the tracking state is dropped.
      state_d = ST_IDLE;
      cnt_d   = '0;
      lost_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (rise) begin
            state_d = ST_MEASURE;
            cnt_d   = CNT_ONE;
          end
        end
        ST_MEASURE: begin
          // An edge coinciding with the timeout still counts as a measurement.
          if (rise) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            in_range_d     = cnt_in_range;
            if (!cnt_in_range && (err_q != ERR_SAT)) begin
              err_d = err_q + ERR_ONE;
            end
            cnt_d = CNT_ONE;
          end else if (cnt_q == TO_C) begin
            state_d    = ST_LOST;
            lost_d     = 1'b1;
            in_range_d = 1'b0;
            cnt_d      = TO_C;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_LOST: begin
          cnt_d = TO_C;
          // The interval spanning the loss is meaningless, so just re-arm.
          if (rise) begin
            state_d = ST_MEASURE;
            lost_d  = 1'b0;
            cnt_d   = CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM and measurement registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      lost_q         <= 1'b0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      in_range_q     <= in_range_d;
      lost_q         <= lost_d;
      err_q          <= err_d;
    end
  end

  assign edge_pulse   = edge_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;
  assign lost         = lost_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: drives tick_in as a sequence of rise-to-rise
// gaps and predicts each window's outcome from the gap list alone.
module tb_tick_period_meter;

  localparam int CNT_W = 32;
  localparam int SYNC  = 2;
  localparam int MINP  = 8;
  localparam int MAXP  = 12;
  localparam int TO    = 20;
  localparam int ERR_W = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             tick_in;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             in_range;
  logic             lost;
  logic [ERR_W-1:0] err_count;

  int total = 0;
  int bad   = 0;

  // Reference model: what the meter should report, in terms of gaps.
  bit m_armed;
  int m_err;
  int m_period;
  bit m_inr;
  int m_prev_gap;

  tick_period_meter #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
    .TIMEOUT_CYCLES(TO), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick_in(tick_in),
    .edge_pulse(edge_pulse), .period(period), .period_valid(period_valid),
    .in_range(in_range), .lost(lost), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_armed    = 1'b0;
    m_err      = 0;
    m_period   = 0;
    m_inr      = 1'b0;
    m_prev_gap = 0;
  endtask

  // One tick rise followed by g-1 more cycles before the next rise.
  // dis_at >= 0 drops enable for 3 cycles starting at that cycle offset.
  task automatic run_gap(input int g, input int dis_at);
    int               hi, nv, ne;
    bit               ev;
    logic [CNT_W-1:0] got_p;
    ev = 1'b0;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (m_prev_gap > TO) begin
      m_inr = 1'b0;
    end else begin
      ev       = 1'b1;
      m_period = m_prev_gap;
      m_inr    = (m_prev_gap >= MINP) && (m_prev_gap <= MAXP);
      if (!m_inr && m_err < ERR_MAX) m_err++;
    end
    hi    = (g / 2 < 1) ? 1 : g / 2;
    nv    = 0;
    ne    = 0;
    got_p = '0;
    tick_in = 1'b1;
    for (int c = 0; c < g; c++) begin
      if (c == hi) tick_in = 1'b0;
      if (dis_at >= 0 && c == dis_at) enable = 1'b0;
      if (dis_at >= 0 && c == dis_at + 3) enable = 1'b1;
      @(negedge clk);
      if (period_valid) begin
        nv++;
        got_p = period;
      end
      if (edge_pulse) ne++;
    end
    if (dis_at >= 0) m_armed = 1'b0;
    m_prev_gap = g;

    total++;
    if (ne !== 1) begin
      bad++;
      $display("FAIL edge_count gap=%0d got=%0d exp=1", g, ne);
    end
    total++;
    if (nv !== (ev ? 1 : 0)) begin
      bad++;
      $display("FAIL valid_count gap=%0d got=%0d exp=%0d", g, nv, ev ? 1 : 0);
    end
    if (ev && nv == 1) begin
      total++;
      if (got_p !== CNT_W'(m_period)) begin
        bad++;
        $display("FAIL valid_period gap=%0d got=%0d exp=%0d", g, got_p, m_period);
      end
    end
    total++;
    if (period !== CNT_W'(m_period)) begin
      bad++;
      $display("FAIL period_hold gap=%0d got=%0d exp=%0d", g, period, m_period);
    end
    total++;
    if (err_count !== ERR_W'(m_err)) begin
      bad++;
      $display("FAIL err_count gap=%0d got=%0d exp=%0d", g, err_count, m_err);
    end
    if (!m_armed || g <= TO) begin
      total++;
      if (lost !== 1'b0) begin
        bad++;
        $display("FAIL lost_low gap=%0d got=%0b exp=0", g, lost);
      end
      total++;
      if (in_range !== m_inr) begin
        bad++;
        $display("FAIL in_range gap=%0d got=%0b exp=%0b", g, in_range, m_inr);
      end
    end else if (g >= TO + 4) begin
      total++;
      if (lost !== 1'b1) begin
        bad++;
        $display("FAIL lost_high gap=%0d got=%0b exp=1", g, lost);
      end
      total++;
      if (in_range !== 1'b0) begin
        bad++;
        $display("FAIL in_range_lost gap=%0d got=%0b exp=0", g, in_range);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if (edge_pulse !== 1'b0 || period_valid !== 1'b0 || in_range !== 1'b0 ||
        lost !== 1'b0) begin
      bad++;
      $display("FAIL %s_flags got ep=%0b pv=%0b ir=%0b lost=%0b exp all 0",
               tag, edge_pulse, period_valid, in_range, lost);
    end
    total++;
    if (period !== '0) begin
      bad++;
      $display("FAIL %s_period got=%0d exp=0", tag, period);
    end
    total++;
    if (err_count !== '0) begin
      bad++;
      $display("FAIL %s_err got=%0d exp=0", tag, err_count);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset  = 1'b0;
    enable = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_steady();
    for (int i = 0; i < 6; i++) run_gap(10, -1);
  endtask

  task automatic test_out_of_range();
    run_gap(7, -1);
    run_gap(13, -1);
    run_gap(8, -1);
    run_gap(10, -1);
  endtask

  task automatic test_timeout();
    run_gap(30, -1);
    run_gap(10, -1);
    run_gap(10, -1);
    run_gap(10, -1);
  endtask

  task automatic test_edge_at_timeout();
    run_gap(20, -1);
    run_gap(10, -1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 18; i++) run_gap(5, -1);
    run_gap(10, -1);
    total++;
    if (err_count !== ERR_W'(ERR_MAX)) begin
      bad++;
      $display("FAIL err_saturate got=%0d exp=%0d", err_count, ERR_MAX);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_gap(int'($urandom_range(30, 5)), -1);
  endtask

  task automatic test_enable();
    run_gap(10, -1);
    run_gap(10, 4);
    run_gap(10, -1);
    run_gap(10, -1);
  endtask

  task automatic test_reset_mid();
    run_gap(10, -1);
    run_gap(13, -1);
    tick_in = 1'b1;
    repeat (3) @(negedge clk);
    tick_in = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    run_gap(10, -1);
    run_gap(11, -1);
    run_gap(10, -1);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_out_of_range();
    test_timeout();
    test_edge_at_timeout();
    test_saturation();
    test_random();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
